reg_pipe_chain: RTL and testbench



---
 rtl/dsp_pkg.sv | 13 +
 rtl/pipe_stage.sv | 29 ++
 rtl/reg_pipe_chain.sv | 124 ++++++++++++
 tb/tb_reg_pipe_chain.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP pipeline blocks.
package dsp_pkg;

  localparam int MAX_PIPE_DEPTH = 8;

  // Width of an occupancy counter able to hold 0..depth; never narrower than 1 bit.
  function automatic int occ_width(input int depth);
    int w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One register stage of the elastic chain: valid bit plus data, loaded when enabled.
module pipe_stage #(
  parameter int WIDTH = 18
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr,
  input  logic             en,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Data only moves with a valid source, so bubbles never overwrite held data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (en) begin
      valid <= src_valid;
      if (src_valid) data <= src_data;
    end
  end

endmodule

// File: rtl/reg_pipe_chain.sv
// DEPTH-stage register chain with valid/ready backpressure, bubble collapse and occupancy count.
module reg_pipe_chain
  import dsp_pkg::*;
#(
  parameter  int WIDTH = 18,
  parameter  int DEPTH = 2,
  localparam int OCC_W = occ_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             SCLR,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [OCC_W-1:0] occupancy
);

  if (DEPTH < 0 || DEPTH > MAX_PIPE_DEPTH) begin : g_bad_depth
    $error("reg_pipe_chain: DEPTH out of range");
  end

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, CLK, RST_N, CE, SCLR};
    assign out         = in;
    assign out_valid   = in_valid;
    assign in_ready    = out_ready;
    assign occupancy   = '0;
  end else begin : g_chain
    logic             run;
    logic [DEPTH:0]   en;
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] d     [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [OCC_W-1:0] occ;
    logic             accept;
    logic             emit;

    // Reset is folded in so in_ready stays low while RST_N is held.
    assign run = RST_N & CE & ~SCLR;

    // Ready ripples back from out_ready; an empty stage always accepts.
    always_comb begin
      en        = '0;
      en[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        en[i] = run & (~v[i] | en[i+1]);
      end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_src
        assign src_v[g] = in_valid;
        assign src_d[g] = in;
      end else begin : g_src
        assign src_v[g] = v[g-1];
        assign src_d[g] = d[g-1];
      end

      pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .clr       (SCLR),
        .en        (en[g]),
        .src_valid (src_v[g]),
        .src_data  (src_d[g]),
        .valid     (v[g]),
        .data      (d[g])
      );
    end

    assign in_ready  = en[0];
    assign out_valid = v[DEPTH-1];
    assign out       = d[DEPTH-1];
    assign accept    = in_valid & en[0];
    assign emit      = out_valid & out_ready & run;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        occ <= '0;
      end else if (SCLR) begin
        occ <= '0;
      end else if (CE) begin
        if (accept && !emit)      occ <= occ + OCC_W'(1);
        else if (emit && !accept) occ <= occ - OCC_W'(1);
      end
    end

    assign occupancy = occ;

`ifndef SYNTHESIS
    logic             chk_hold;
    logic [WIDTH-1:0] chk_out;

    always @(posedge CLK) begin
      if (RST_N) begin
        assert (occ == OCC_W'($countones(v)))
          else $error("reg_pipe_chain: occupancy %0d disagrees with valid bits %b", occ, v);
      end
    end

    // A stalled output word must not change until it is taken or flushed.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        chk_hold <= 1'b0;
        chk_out  <= '0;
      end else begin
        chk_hold <= out_valid & ~out_ready & ~SCLR;
        chk_out  <= out;
        if (chk_hold) begin
          assert (out_valid && out == chk_out)
            else $error("reg_pipe_chain: stalled output changed");
        end
      end
    end
`endif
  end

endmodule

// File: tb/tb_reg_pipe_chain.sv
// Self-checking bench for reg_pipe_chain: DEPTH=3 chain against an item-level model, plus a DEPTH=0 bypass.
module tb_reg_pipe_chain;

  localparam int W = 18;
  localparam int D = 3;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic         ce, sclr, iv, ordy, ir, ov;
  logic [W-1:0] din, dout;
  logic [1:0]   occ;

  logic         ce0, sclr0, iv0, ordy0, ir0, ov0;
  logic [W-1:0] din0, dout0;
  logic [0:0]   occ0;

  reg_pipe_chain #(.WIDTH(W), .DEPTH(D)) u3 (
    .CLK(CLK), .RST_N(RST_N), .CE(ce), .SCLR(sclr),
    .in_valid(iv), .in_ready(ir), .in(din),
    .out_valid(ov), .out_ready(ordy), .out(dout), .occupancy(occ)
  );

  reg_pipe_chain #(.WIDTH(W), .DEPTH(0)) u0 (
    .CLK(CLK), .RST_N(RST_N), .CE(ce0), .SCLR(sclr0),
    .in_valid(iv0), .in_ready(ir0), .in(din0),
    .out_valid(ov0), .out_ready(ordy0), .out(dout0), .occupancy(occ0)
  );

  int checks = 0;
  int failures = 0;

  // Model: items oldest-first, each with its slot position (0 = input stage, D-1 = output).
  logic [W-1:0] m_d[$];
  int           m_p[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_run();
    return RST_N && ce && !sclr;
  endfunction

  // An item advances if the slot ahead is empty or the item ahead is itself advancing.
  function automatic logic [7:0] m_moves();
    logic [7:0] mv;
    mv = '0;
    if (m_run()) begin
      for (int k = 0; k < m_p.size(); k++) begin
        if (k == 0) mv[k] = (m_p[0] == D - 1) ? ordy : 1'b1;
        else        mv[k] = (m_p[k-1] != m_p[k] + 1) || mv[k-1];
      end
    end
    return mv;
  endfunction

  function automatic bit m_in_ready();
    logic [7:0] mv;
    int n;
    mv = m_moves();
    n  = m_p.size();
    if (!m_run()) return 1'b0;
    return (n == 0) || (m_p[n-1] != 0) || mv[n-1];
  endfunction

  task automatic m_advance();
    logic [7:0] mv;
    bit acc;
    if (sclr) begin
      m_d.delete();
      m_p.delete();
    end else if (ce) begin
      mv  = m_moves();
      acc = iv && m_in_ready();
      for (int k = 0; k < m_p.size(); k++) if (mv[k]) m_p[k] = m_p[k] + 1;
      if (m_p.size() > 0 && m_p[0] == D) begin
        void'(m_p.pop_front());
        void'(m_d.pop_front());
      end
      if (acc) begin
        m_d.push_back(din);
        m_p.push_back(0);
      end
    end
  endtask

  task automatic check_model(input string tag);
    bit exp_ov;
    exp_ov = (m_p.size() > 0) && (m_p[0] == D - 1);
    chk($sformatf("%s in_ready", tag), 32'(ir), 32'(m_in_ready()));
    chk($sformatf("%s out_valid", tag), 32'(ov), 32'(exp_ov));
    chk($sformatf("%s occupancy", tag), 32'(occ), 32'(m_p.size()));
    if (exp_ov) chk($sformatf("%s out", tag), 32'(dout), 32'(m_d[0]));
  endtask

  // One clock cycle: settle, compare against model, then take the edge.
  task automatic step(input string tag);
    #1;
    check_model(tag);
    m_advance();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic         iv;
    logic [W-1:0] din;
    logic         ordy;
    logic         exp_ir;
    logic         exp_ov;
    logic [W-1:0] exp_out;
    int           exp_occ;
  } bp_vec_t;

  typedef struct {
    logic [W-1:0] din;
    logic         iv;
    logic         ordy;
    logic         ce;
    logic         sclr;
    logic [W-1:0] exp_out;
    logic         exp_ov;
    logic         exp_ir;
  } byp_vec_t;

  bp_vec_t  bp_tab[11];
  byp_vec_t byp_tab[6];

  initial begin
    int first_acc, first_ov, last_ov, sent, bad_occ;
    logic [W-1:0] got[$];

    bp_tab[0]  = '{1'b1, 18'h00001, 1'b0, 1'b1, 1'b0, 18'h00000, 0};
    bp_tab[1]  = '{1'b1, 18'h00002, 1'b0, 1'b1, 1'b0, 18'h00000, 1};
    bp_tab[2]  = '{1'b1, 18'h00003, 1'b0, 1'b1, 1'b0, 18'h00000, 2};
    bp_tab[3]  = '{1'b1, 18'h00004, 1'b0, 1'b0, 1'b1, 18'h00001, 3};
    bp_tab[4]  = '{1'b1, 18'h00004, 1'b0, 1'b0, 1'b1, 18'h00001, 3};
    bp_tab[5]  = '{1'b1, 18'h00004, 1'b1, 1'b1, 1'b1, 18'h00001, 3};
    bp_tab[6]  = '{1'b1, 18'h00005, 1'b1, 1'b1, 1'b1, 18'h00002, 3};
    bp_tab[7]  = '{1'b0, 18'h00000, 1'b1, 1'b1, 1'b1, 18'h00003, 3};
    bp_tab[8]  = '{1'b0, 18'h00000, 1'b1, 1'b1, 1'b1, 18'h00004, 2};
    bp_tab[9]  = '{1'b0, 18'h00000, 1'b1, 1'b1, 1'b1, 18'h00005, 1};
    bp_tab[10] = '{1'b0, 18'h00000, 1'b1, 1'b1, 1'b0, 18'h00000, 0};

    byp_tab[0] = '{18'h2A5A5, 1'b1, 1'b1, 1'b1, 1'b0, 18'h2A5A5, 1'b1, 1'b1};
    byp_tab[1] = '{18'h2A5A5, 1'b1, 1'b0, 1'b1, 1'b0, 18'h2A5A5, 1'b1, 1'b0};
    byp_tab[2] = '{18'h2A5A5, 1'b1, 1'b1, 1'b0, 1'b0, 18'h2A5A5, 1'b1, 1'b1};
    byp_tab[3] = '{18'h2A5A5, 1'b1, 1'b0, 1'b1, 1'b1, 18'h2A5A5, 1'b1, 1'b0};
    byp_tab[4] = '{18'h1FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 18'h1FFFF, 1'b0, 1'b1};
    byp_tab[5] = '{18'h00000, 1'b1, 1'b0, 1'b1, 1'b0, 18'h00000, 1'b1, 1'b0};

    ce = 1'b1; sclr = 1'b0; iv = 1'b0; ordy = 1'b0; din = '0;
    ce0 = 1'b1; sclr0 = 1'b0; iv0 = 1'b0; ordy0 = 1'b0; din0 = '0;

    // Reset state, then an asynchronous reset with items in flight.
    #2;
    chk("reset out", 32'(dout), 32'h0);
    chk("reset out_valid", 32'(ov), 32'h0);
    chk("reset occupancy", 32'(occ), 32'h0);
    chk("reset in_ready", 32'(ir), 32'h0);
    #10 RST_N = 1'b1;
    @(posedge CLK); #1;
    iv = 1'b1; din = 18'h0AAAA; step("rst fill");
    din = 18'h15555; step("rst fill");
    iv = 1'b0; step("rst fill");
    chk("held out_valid", 32'(ov), 32'h1);
    #3 RST_N = 1'b0;
    #1;
    m_d.delete(); m_p.delete();
    chk("midrst out", 32'(dout), 32'h0);
    chk("midrst out_valid", 32'(ov), 32'h0);
    chk("midrst occupancy", 32'(occ), 32'h0);
    chk("midrst in_ready", 32'(ir), 32'h0);
    #1 RST_N = 1'b1;
    #1;
    chk("release in_ready", 32'(ir), 32'h1);
    @(posedge CLK); #1;

    // Back-to-back streaming of 1..16.
    first_acc = -1; first_ov = -1; last_ov = -1; sent = 0; bad_occ = 0;
    ordy = 1'b1;
    for (int c = 0; c < 40 && got.size() < 16; c++) begin
      iv  = (sent < 16);
      din = W'(sent + 1);
      #1;
      if (iv && ir) begin
        if (first_acc < 0) first_acc = c;
        sent++;
      end
      if (ov && ordy) begin
        if (first_ov < 0) first_ov = c;
        last_ov = c;
        got.push_back(dout);
      end
      if (c >= 3 && c <= 16 && occ != 2'd3) bad_occ++;
      step("stream");
    end
    iv = 1'b0;
    chk("stream latency", 32'(first_ov - first_acc), 32'd3);
    chk("stream count", 32'(got.size()), 32'd16);
    chk("stream no gaps", 32'(last_ov - first_ov), 32'd15);
    chk("stream steady occupancy", 32'(bad_occ), 32'd0);
    for (int i = 0; i < got.size(); i++) chk($sformatf("stream order %0d", i), 32'(got[i]), 32'(i + 1));

    // Backpressure fill and drain.
    for (int r = 0; r < 11; r++) begin
      iv = bp_tab[r].iv; din = bp_tab[r].din; ordy = bp_tab[r].ordy;
      #1;
      chk($sformatf("bp[%0d] in_ready", r), 32'(ir), 32'(bp_tab[r].exp_ir));
      chk($sformatf("bp[%0d] out_valid", r), 32'(ov), 32'(bp_tab[r].exp_ov));
      chk($sformatf("bp[%0d] occupancy", r), 32'(occ), 32'(bp_tab[r].exp_occ));
      if (bp_tab[r].exp_ov) chk($sformatf("bp[%0d] out", r), 32'(dout), 32'(bp_tab[r].exp_out));
      step("bp");
    end

    // Bubble collapse: items in stages 0 and 2, then one stalled edge compacts them.
    ordy = 1'b0;
    iv = 1'b1; din = 18'h0ABCD; step("bub");
    iv = 1'b0; step("bub");
    iv = 1'b1; din = 18'h12345; step("bub");
    iv = 1'b0; step("bub compact");
    ordy = 1'b1;
    #1;
    chk("bub head valid", 32'(ov), 32'h1);
    chk("bub head data", 32'(dout), 32'h0ABCD);
    chk("bub occupancy", 32'(occ), 32'd2);
    step("bub drain");
    #1;
    chk("bub second valid", 32'(ov), 32'h1);
    chk("bub second data", 32'(dout), 32'h12345);
    step("bub drain");
    #1;
    chk("bub empty", 32'(ov), 32'h0);
    step("bub drain");

    // CE freeze, then SCLR with CE low.
    ordy = 1'b0;
    iv = 1'b1; din = 18'h00011; step("ce fill");
    din = 18'h00022; step("ce fill");
    iv = 1'b0; step("ce fill");
    ce = 1'b0; iv = 1'b1; din = 18'h00033; ordy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("ce0[%0d] in_ready", c), 32'(ir), 32'h0);
      chk($sformatf("ce0[%0d] out_valid", c), 32'(ov), 32'h1);
      chk($sformatf("ce0[%0d] out", c), 32'(dout), 32'h00011);
      chk($sformatf("ce0[%0d] occupancy", c), 32'(occ), 32'd2);
      step("ce0");
    end
    sclr = 1'b1;
    #1;
    chk("sclr in_ready", 32'(ir), 32'h0);
    step("sclr");
    sclr = 1'b0; ce = 1'b1; iv = 1'b0;
    #1;
    chk("sclr out_valid", 32'(ov), 32'h0);
    chk("sclr occupancy", 32'(occ), 32'h0);
    chk("sclr out", 32'(dout), 32'h0);
    step("post sclr");

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      iv   = 1'($urandom_range(0, 1));
      din  = W'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      ce   = ($urandom_range(0, 9) != 0);
      sclr = ($urandom_range(0, 49) == 0);
      step("rand");
    end
    ce = 1'b1; sclr = 1'b0; iv = 1'b0;

    // DEPTH=0 bypass.
    for (int r = 0; r < 6; r++) begin
      din0 = byp_tab[r].din; iv0 = byp_tab[r].iv; ordy0 = byp_tab[r].ordy;
      ce0 = byp_tab[r].ce; sclr0 = byp_tab[r].sclr;
      #1;
      chk($sformatf("byp[%0d] out", r), 32'(dout0), 32'(byp_tab[r].exp_out));
      chk($sformatf("byp[%0d] out_valid", r), 32'(ov0), 32'(byp_tab[r].exp_ov));
      chk($sformatf("byp[%0d] in_ready", r), 32'(ir0), 32'(byp_tab[r].exp_ir));
      chk($sformatf("byp[%0d] occupancy", r), 32'(occ0), 32'h0);
      @(posedge CLK); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
